// File: rtl/ifft_bitrev_reorder.sv
// rtl/ifft_bitrev_reorder.sv - bit-reversed to natural order reorder with ping-pong banks and optional 1/NFFT scaling
module ifft_bitrev_reorder #(
    parameter int INTEGER_SIZE = 8,
    parameter int FRACT_SIZE   = 8,
    parameter int NFFT         = 128,
    parameter int SCALE_EN     = 1,
    localparam int DATA_WIDTH  = INTEGER_SIZE + FRACT_SIZE,
    localparam int L           = $clog2(NFFT)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    input  logic                         in_start,
    input  logic signed [DATA_WIDTH-1:0] serial_in_r,
    input  logic signed [DATA_WIDTH-1:0] serial_in_i,
    output logic                         out_valid,
    output logic                         out_last,
    output logic signed [DATA_WIDTH-1:0] serial_out_r,
    output logic signed [DATA_WIDTH-1:0] serial_out_i
);

    localparam logic [0:0]   IDLE     = 1'b0;
    localparam logic [0:0]   READ     = 1'b1;
    localparam logic [L-1:0] LAST_IDX = L'(NFFT - 1);

    // Both banks share one array; the bank select is the top address bit.
    logic [2*DATA_WIDTH-1:0] mem [0:2*NFFT-1];

    logic [0:0]              state;
    logic                    wbank;
    logic                    rbank;
    logic [L-1:0]            wcnt;
    logic [L-1:0]            rcnt;
    logic [L-1:0]            n_idx;
    logic                    wr_done;
    logic [2*DATA_WIDTH-1:0] rd_word;
    logic                    rd_valid;
    logic                    rd_last;

    function automatic logic [L-1:0] bitrev(input logic [L-1:0] v);
        logic [L-1:0] r;
        for (int b = 0; b < L; b++) begin
            r[b] = v[L-1-b];
        end
        return r;
    endfunction

    // Round-half-up divide by NFFT; one guard bit keeps the add from overflowing.
    function automatic logic [DATA_WIDTH-1:0] scale(input logic [DATA_WIDTH-1:0] x);
        logic signed [DATA_WIDTH:0] sum;
        sum = {x[DATA_WIDTH-1], x} + (DATA_WIDTH+1)'(NFFT / 2);
        if (SCALE_EN != 0) begin
            return DATA_WIDTH'(sum >>> L);
        end
        return x;
    endfunction

    always_comb begin
        n_idx   = in_start ? '0 : wcnt;
        wr_done = in_valid && (n_idx == LAST_IDX);
    end

    always_ff @(posedge clk) begin
        if (in_valid) begin
            mem[{wbank, bitrev(n_idx)}] <= {serial_in_r, serial_in_i};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wcnt  <= '0;
            wbank <= 1'b0;
        end else if (in_valid) begin
            if (wr_done) begin
                wcnt  <= '0;
                wbank <= ~wbank;
            end else begin
                wcnt <= n_idx + 1'b1;
            end
        end
    end

    // A bank completing on the final read cycle chains straight into the next readout.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            rcnt  <= '0;
            rbank <= 1'b0;
        end else if (wr_done && (state == IDLE || rcnt == LAST_IDX)) begin
            state <= READ;
            rcnt  <= '0;
            rbank <= wbank;
        end else if (state == READ) begin
            if (rcnt == LAST_IDX) begin
                state <= IDLE;
            end
            rcnt <= rcnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        rd_word <= mem[{rbank, rcnt}];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_valid <= 1'b0;
            rd_last  <= 1'b0;
        end else begin
            rd_valid <= (state == READ);
            rd_last  <= (state == READ) && (rcnt == LAST_IDX);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid    <= 1'b0;
            out_last     <= 1'b0;
            serial_out_r <= '0;
            serial_out_i <= '0;
        end else begin
            out_valid <= rd_valid;
            out_last  <= rd_last;
            if (rd_valid) begin
                serial_out_r <= scale(rd_word[2*DATA_WIDTH-1:DATA_WIDTH]);
                serial_out_i <= scale(rd_word[DATA_WIDTH-1:0]);
            end
        end
    end

endmodule

// File: tb/tb_ifft_bitrev_reorder.sv
// tb/tb_ifft_bitrev_reorder.sv - self-checking bench for ifft_bitrev_reorder
module tb_ifft_bitrev_reorder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [15:0] r;
        logic [15:0] i;
        logic        last;
        int          cyc;
    } obs_t;

    typedef struct {
        logic [15:0] in_r;
        logic [15:0] in_i;
        logic [15:0] exp_r;
        logic [15:0] exp_i;
        logic        exp_last;
    } vec_t;

    typedef struct {
        logic [15:0] in_v;
        logic [15:0] exp_v;
    } sc_t;

    obs_t qa[$], qb[$], qc[$], exp_a[$];
    logic [15:0] mf_r[$], mf_i[$];

    logic        a_valid = 0, a_start = 0, a_ov, a_ol;
    logic [15:0] a_in_r = 0, a_in_i = 0, a_out_r, a_out_i;
    logic        b_valid = 0, b_start = 0, b_ov, b_ol;
    logic [15:0] b_in_r = 0, b_in_i = 0, b_out_r, b_out_i;
    logic        c_valid = 0, c_start = 0, c_ov, c_ol;
    logic [15:0] c_in_r = 0, c_in_i = 0, c_out_r, c_out_i;

    ifft_bitrev_reorder #(.INTEGER_SIZE(8), .FRACT_SIZE(8), .NFFT(8), .SCALE_EN(0)) dut_a (
        .clk(clk), .rst(rst), .in_valid(a_valid), .in_start(a_start),
        .serial_in_r(a_in_r), .serial_in_i(a_in_i), .out_valid(a_ov), .out_last(a_ol),
        .serial_out_r(a_out_r), .serial_out_i(a_out_i));

    ifft_bitrev_reorder #(.INTEGER_SIZE(8), .FRACT_SIZE(8), .NFFT(8), .SCALE_EN(1)) dut_b (
        .clk(clk), .rst(rst), .in_valid(b_valid), .in_start(b_start),
        .serial_in_r(b_in_r), .serial_in_i(b_in_i), .out_valid(b_ov), .out_last(b_ol),
        .serial_out_r(b_out_r), .serial_out_i(b_out_i));

    ifft_bitrev_reorder #(.INTEGER_SIZE(8), .FRACT_SIZE(8), .NFFT(128), .SCALE_EN(1)) dut_c (
        .clk(clk), .rst(rst), .in_valid(c_valid), .in_start(c_start),
        .serial_in_r(c_in_r), .serial_in_i(c_in_i), .out_valid(c_ov), .out_last(c_ol),
        .serial_out_r(c_out_r), .serial_out_i(c_out_i));

    always @(negedge clk) begin : mon
        obs_t e;
        if (a_ov) begin e.r = a_out_r; e.i = a_out_i; e.last = a_ol; e.cyc = cyc; qa.push_back(e); end
        if (b_ov) begin e.r = b_out_r; e.i = b_out_i; e.last = b_ol; e.cyc = cyc; qb.push_back(e); end
        if (c_ov) begin e.r = c_out_r; e.i = c_out_i; e.last = c_ol; e.cyc = cyc; qc.push_back(e); end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic int brev(input int x, input int bits);
        int r = 0;
        int v = x;
        for (int b = 0; b < bits; b++) begin
            r = r * 2 + v % 2;
            v = v / 2;
        end
        return r;
    endfunction

    function automatic logic [15:0] scale_ref(input logic [15:0] x, input int nfft);
        int y;
        y = int'($signed(x)) + nfft / 2;
        if (y >= 0) y = y / nfft;
        else        y = -((-y + nfft - 1) / nfft);
        return y[15:0];
    endfunction

    // Frame-level model for dut_a: collect samples, emit in natural order once full.
    task automatic model_a(input logic s, input logic [15:0] r, input logic [15:0] i);
        obs_t e;
        if (s) begin mf_r.delete(); mf_i.delete(); end
        mf_r.push_back(r);
        mf_i.push_back(i);
        if (mf_r.size() == 8) begin
            for (int k = 0; k < 8; k++) begin
                e.r = mf_r[brev(k, 3)]; e.i = mf_i[brev(k, 3)]; e.last = (k == 7); e.cyc = 0;
                exp_a.push_back(e);
            end
            mf_r.delete(); mf_i.delete();
        end
    endtask

    task automatic send_a(input logic v, input logic s, input logic [15:0] r, input logic [15:0] i);
        a_valid = v; a_start = s; a_in_r = r; a_in_i = i;
        if (v) model_a(s, r, i);
        @(posedge clk); #1;
        a_valid = 0; a_start = 0;
    endtask

    task automatic send_frame_a(input logic with_start, input int gaps);
        for (int n = 0; n < 8; n++) begin
            if (gaps != 0) repeat ($urandom_range(0, 2)) send_a(0, 0, 0, 0);
            send_a(1, with_start && (n == 0), 16'($urandom), 16'($urandom));
        end
    endtask

    task automatic compare_a(input string tag);
        for (int w = 0; w < 300 && qa.size() < exp_a.size(); w++) @(negedge clk);
        repeat (14) @(negedge clk);
        #1;
        check($sformatf("%s_count", tag), qa.size(), exp_a.size());
        for (int j = 0; j < qa.size() && j < exp_a.size(); j++)
            check($sformatf("%s_s%0d", tag, j), {qa[j].r, qa[j].i, qa[j].last},
                  {exp_a[j].r, exp_a[j].i, exp_a[j].last});
        qa.delete(); exp_a.delete();
    endtask

    vec_t        tv[8];
    sc_t         sc[8];
    logic [15:0] cr[256], ci[256];

    initial begin
        for (int n = 0; n < 8; n++) begin
            tv[n].in_r     = 16'(brev(n, 3));
            tv[n].in_i     = 16'(-brev(n, 3));
            tv[n].exp_r    = 16'(n);
            tv[n].exp_i    = 16'(-n);
            tv[n].exp_last = (n == 7);
        end
        sc[0] = '{16'h0800, 16'h0100};
        sc[1] = '{16'hFFFD, 16'h0000};
        sc[2] = '{16'h0004, 16'h0001};
        sc[3] = '{16'hFFFB, 16'hFFFF};
        sc[4] = '{16'h7FFF, 16'h1000};
        sc[5] = '{16'h8000, 16'hF000};
        sc[6] = '{16'h0003, 16'h0000};
        sc[7] = '{16'hFFF4, 16'hFFFF};

        #2;
        check("rst_a", {a_ov, a_ol, a_out_r, a_out_i}, 0);
        check("rst_b", {b_ov, b_ol, b_out_r, b_out_i}, 0);
        check("rst_c", {c_ov, c_ol, c_out_r, c_out_i}, 0);
        repeat (2) @(posedge clk);
        #1 rst = 0;

        // Basic reorder with exact latency
        for (int n = 0; n < 8; n++) send_a(1, n == 0, tv[n].in_r, tv[n].in_i);
        @(negedge clk); check("lat_t0", a_ov, 0);
        @(negedge clk); check("lat_t1", a_ov, 0);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check($sformatf("basic_k%0d", k), {a_ov, a_out_r, a_out_i, a_ol},
                  {1'b1, tv[k].exp_r, tv[k].exp_i, tv[k].exp_last});
        end
        @(negedge clk); check("basic_after", a_ov, 0);
        #1 qa.delete(); exp_a.delete();

        // Scaling
        for (int n = 0; n < 8; n++) begin
            b_valid = 1; b_start = (n == 0); b_in_r = sc[n].in_v; b_in_i = sc[7-n].in_v;
            @(posedge clk); #1;
        end
        b_valid = 0; b_start = 0;
        for (int w = 0; w < 50 && qb.size() < 8; w++) @(negedge clk);
        repeat (4) @(negedge clk);
        #1;
        check("scale_count", qb.size(), 8);
        for (int k = 0; k < 8 && k < qb.size(); k++)
            check($sformatf("scale_k%0d", k), {qb[k].r, qb[k].i, qb[k].last},
                  {sc[brev(k, 3)].exp_v, sc[7-brev(k, 3)].exp_v, k == 7});

        // Back-to-back NFFT=128 frames, continuous input
        for (int j = 0; j < 256; j++) begin
            cr[j] = 16'($urandom); ci[j] = 16'($urandom);
            c_valid = 1; c_start = (j == 0); c_in_r = cr[j]; c_in_i = ci[j];
            @(posedge clk); #1;
        end
        c_valid = 0; c_start = 0;
        for (int w = 0; w < 600 && qc.size() < 256; w++) @(negedge clk);
        repeat (10) @(negedge clk);
        #1;
        check("b2b_count", qc.size(), 256);
        for (int j = 0; j < 256 && j < qc.size(); j++) begin
            check($sformatf("b2b_s%0d", j), {qc[j].r, qc[j].i, qc[j].last},
                  {scale_ref(cr[(j/128)*128 + brev(j%128, 7)], 128),
                   scale_ref(ci[(j/128)*128 + brev(j%128, 7)], 128), (j % 128) == 127});
            check($sformatf("b2b_gap%0d", j), qc[j].cyc - qc[0].cyc, j);
        end

        // Gaps, partial frames discarded, in_start at wcnt = NFFT-1, then wcnt=0 start
        send_frame_a(1, 1);
        for (int n = 0; n < 5; n++) send_a(1, n == 0, 16'($urandom), 16'($urandom));
        send_frame_a(1, 1);
        for (int n = 0; n < 7; n++) send_a(1, n == 0, 16'($urandom), 16'($urandom));
        send_frame_a(1, 1);
        send_frame_a(0, 1);
        check("gap_expected_frames", exp_a.size(), 32);
        compare_a("gap");

        // Reset in the middle of a readout
        send_frame_a(1, 0);
        for (int w = 0; w < 40; w++) begin
            @(negedge clk); #1;
            if (qa.size() == 4) break;
        end
        check("rst_reached_s3", qa.size(), 4);
        rst = 1;
        #1;
        check("rst_async", {a_ov, a_ol, a_out_r, a_out_i}, 0);
        qa.delete(); exp_a.delete(); mf_r.delete(); mf_i.delete();
        repeat (3) @(negedge clk);
        check("rst_hold", {a_ov, a_ol, a_out_r, a_out_i}, 0);
        @(posedge clk); #1 rst = 0;
        repeat (20) @(negedge clk);
        #1;
        check("rst_no_stale", qa.size(), 0);
        send_frame_a(1, 0);
        compare_a("post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
